// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the fixed-point FFT datapath blocks.
//   cplx_t       : real/imag pair of FFT_N-bit signed words (default width)
//   fft_sat_max  : largest value representable in a w-bit two's-complement word
//   fft_sat_min  : smallest value representable in a w-bit two's-complement word
// The helpers return 64-bit values so that blocks with any word width up to
// 63 bits can slice out their own saturation limits at elaboration time.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N = 32;

    typedef struct packed {
        logic signed [FFT_N-1:0] re;
        logic signed [FFT_N-1:0] im;
    } cplx_t;

    function automatic logic signed [63:0] fft_sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fft_sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_point_complex_fifo.sv
// ---------------------------------------------------------------------------
// fixed_point_complex_fifo
// Circular buffer of complex words (real/imag, n bits each) with val/rdy on
// both sides. Storage is not reset; only pointers and occupancy are.
// A word written in cycle t is visible at the read side from cycle t+1.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_val/in_rdy     write handshake; in_rdy = (count < ADEPTH)
//   in_re/in_im       write data
//   out_val/out_rdy   read handshake; out_val = (count != 0)
//   out_re/out_im     head-of-queue data
//   count             current occupancy (0..ADEPTH)
// ---------------------------------------------------------------------------
module fixed_point_complex_fifo
    import fft_pkg::*;
#(
    parameter int n      = 32,
    parameter int ADEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [n-1:0]             in_re,
    input  logic [n-1:0]             in_im,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [n-1:0]             out_re,
    output logic [n-1:0]             out_im,
    output logic [$clog2(ADEPTH):0]  count
);

    localparam int AW = $clog2(ADEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(ADEPTH);

    logic [2*n-1:0] r_mem [ADEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    // Full is judged on the registered count alone, so a pop in the same
    // cycle never frees a slot for a push.
    assign in_rdy  = (r_count < FULL_CNT);
    assign out_val = (r_count != '0);
    assign w_push  = in_val && in_rdy;
    assign w_pop   = out_val && out_rdy;
    assign count   = r_count;
    assign out_re  = r_mem[r_rptr][2*n-1:n];
    assign out_im  = r_mem[r_rptr][n-1:0];

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= {in_re, in_im};
        end
    end

    // ADEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_butterfly_join.sv
// ---------------------------------------------------------------------------
// fixed_point_butterfly_join
// Radix-2 butterfly back end: pairs operand A (buffered, it arrives ahead of
// the product) with product P = w*b and produces X = A+P, Y = A-P through a
// one-entry output register.
// Build option: define FIXED_POINT_BUTTERFLY_SAT_EN to saturate each result
// component and raise the sticky ovf flag; otherwise results wrap and ovf=0.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   a_val/a_rdy, ar/ac         operand A in (real/imag)
//   p_val/p_rdy, pr/pc         product in (real/imag)
//   send_val/send_rdy          result out handshake
//   xr/xc, yr/yc               A+P and A-P (real/imag)
//   ovf                        sticky saturation flag
//   a_count                    operand-A buffer occupancy
// Parameter d (fractional bits) is informational only.
// ---------------------------------------------------------------------------
module fixed_point_butterfly_join
    import fft_pkg::*;
#(
    parameter int n      = 32,
    parameter int d      = 16,
    parameter int ADEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_val,
    output logic                     a_rdy,
    input  logic [n-1:0]             ar,
    input  logic [n-1:0]             ac,
    input  logic                     p_val,
    output logic                     p_rdy,
    input  logic [n-1:0]             pr,
    input  logic [n-1:0]             pc,
    output logic                     send_val,
    input  logic                     send_rdy,
    output logic [n-1:0]             xr,
    output logic [n-1:0]             xc,
    output logic [n-1:0]             yr,
    output logic [n-1:0]             yc,
    output logic                     ovf,
    output logic [$clog2(ADEPTH):0]  a_count
);

    if (ADEPTH < 2 || (ADEPTH & (ADEPTH - 1)) != 0) begin : g_bad_depth
        $error("ADEPTH must be a power of two and at least 2");
    end
    if (d < 0 || d >= n) begin : g_bad_frac
        $error("d must lie in [0, n)");
    end

    logic                w_a_val;
    logic signed [n-1:0] w_a_re;
    logic signed [n-1:0] w_a_im;
    logic                w_out_free;
    logic                w_join;
    logic signed [n-1:0] w_xr_p0, w_xc_p0, w_yr_p0, w_yc_p0;
    logic                r_vld_p1;
    logic signed [n-1:0] r_xr_p1, r_xc_p1, r_yr_p1, r_yc_p1;

    fixed_point_complex_fifo #(
        .n      (n),
        .ADEPTH (ADEPTH)
    ) u_afifo (
        .clk     (clk),
        .reset   (reset),
        .in_val  (a_val),
        .in_rdy  (a_rdy),
        .in_re   (ar),
        .in_im   (ac),
        .out_val (w_a_val),
        .out_rdy (w_join),
        .out_re  (w_a_re),
        .out_im  (w_a_im),
        .count   (a_count)
    );

    // A join needs a buffered A and room in the output register; the
    // register is free when empty or being drained this cycle.
    assign w_out_free = !r_vld_p1 || send_rdy;
    assign p_rdy      = w_a_val && w_out_free;
    assign w_join     = p_val && p_rdy;

    // ---- stage p0: add/sub on the head of the A buffer and the product ----
`ifdef FIXED_POINT_BUTTERFLY_SAT_EN
    localparam logic signed [63:0] SMAX64 = fft_sat_max(n);
    localparam logic signed [63:0] SMIN64 = fft_sat_min(n);
    localparam logic signed [n-1:0] SMAX  = SMAX64[n-1:0];
    localparam logic signed [n-1:0] SMIN  = SMIN64[n-1:0];

    // Returns {saturated, result}; the extra bit catches carry into the sign.
    function automatic logic [n:0] addsub_sat(input logic signed [n-1:0] a,
                                              input logic signed [n-1:0] b,
                                              input logic                sub);
        logic [n:0] wide;
        wide = sub ? ({a[n-1], a} - {b[n-1], b}) : ({a[n-1], a} + {b[n-1], b});
        if (wide[n] == wide[n-1]) return {1'b0, wide[n-1:0]};
        else if (wide[n])         return {1'b1, SMIN};
        else                      return {1'b1, SMAX};
    endfunction

    logic w_sat_xr, w_sat_xc, w_sat_yr, w_sat_yc;
    logic r_ovf;

    assign {w_sat_xr, w_xr_p0} = addsub_sat(w_a_re, pr, 1'b0);
    assign {w_sat_xc, w_xc_p0} = addsub_sat(w_a_im, pc, 1'b0);
    assign {w_sat_yr, w_yr_p0} = addsub_sat(w_a_re, pr, 1'b1);
    assign {w_sat_yc, w_yc_p0} = addsub_sat(w_a_im, pc, 1'b1);

    always_ff @(posedge clk) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_join && (w_sat_xr || w_sat_xc || w_sat_yr || w_sat_yc))
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`else
    assign w_xr_p0 = w_a_re + $signed(pr);
    assign w_xc_p0 = w_a_im + $signed(pc);
    assign w_yr_p0 = w_a_re - $signed(pr);
    assign w_yc_p0 = w_a_im - $signed(pc);
    assign ovf     = 1'b0;
`endif

    // ---- stage p1: output register, reloaded on every join ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_xr_p1  <= '0;
            r_xc_p1  <= '0;
            r_yr_p1  <= '0;
            r_yc_p1  <= '0;
        end else if (w_join) begin
            r_vld_p1 <= 1'b1;
            r_xr_p1  <= w_xr_p0;
            r_xc_p1  <= w_xc_p0;
            r_yr_p1  <= w_yr_p0;
            r_yc_p1  <= w_yc_p0;
        end else if (send_rdy) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign send_val = r_vld_p1;
    assign xr       = r_xr_p1;
    assign xc       = r_xc_p1;
    assign yr       = r_yr_p1;
    assign yc       = r_yc_p1;

endmodule

// File: tb/tb_fixed_point_butterfly_join.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_butterfly_join
// Directed scenarios plus randomized traffic, checked against a queue-based
// behavioural model of the butterfly join (n=32, d=16, ADEPTH=4).
// ---------------------------------------------------------------------------
module tb_fixed_point_butterfly_join;
    import fft_pkg::*;

    localparam int N  = 32;
    localparam int AD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_val, a_rdy, p_val, p_rdy, send_val, send_rdy, ovf;
    logic [N-1:0]  ar, ac, pr, pc, xr, xc, yr, yc;
    logic [2:0]    a_count;

    fixed_point_butterfly_join #(.n(N), .d(16), .ADEPTH(AD)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_val    (a_val),
        .a_rdy    (a_rdy),
        .ar       (ar),
        .ac       (ac),
        .p_val    (p_val),
        .p_rdy    (p_rdy),
        .pr       (pr),
        .pc       (pc),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .xr       (xr),
        .xc       (xc),
        .yr       (yr),
        .yc       (yc),
        .ovf      (ovf),
        .a_count  (a_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- behavioural model ----
    cplx_t       m_aq[$];
    bit          m_pend;
    logic [31:0] m_xr, m_xc, m_yr, m_yc;
    bit          m_ovf;

    function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input bit sub, inout bit sat);
        longint s;
        s = sub ? (longint'($signed(a)) - longint'($signed(b)))
                : (longint'($signed(a)) + longint'($signed(b)));
`ifdef FIXED_POINT_BUTTERFLY_SAT_EN
        if (s > 64'sd2147483647)  begin sat = 1'b1; return 32'h7FFF_FFFF; end
        if (s < -64'sd2147483648) begin sat = 1'b1; return 32'h8000_0000; end
`endif
        return 32'(s);
    endfunction

    task automatic model_reset();
        m_aq.delete();
        m_pend = 1'b0;
        m_xr = '0; m_xc = '0; m_yr = '0; m_yc = '0;
        m_ovf = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check the DUT
    // against the model, then advance the model across the rising edge.
    task automatic step(input bit rs, input bit av, input logic [31:0] a_r, input logic [31:0] a_c,
                        input bit pv, input logic [31:0] p_r, input logic [31:0] p_c,
                        input bit sr, output bit joined);
        bit    e_ardy, e_prdy, push, jn, sat;
        cplx_t a;
        @(negedge clk);
        reset = rs; a_val = av; ar = a_r; ac = a_c;
        p_val = pv; pr = p_r; pc = p_c; send_rdy = sr;
        #1;
        e_ardy = (m_aq.size() < AD);
        e_prdy = (m_aq.size() != 0) && (!m_pend || sr);
        check_val("a_count",  a_count, m_aq.size());
        check_val("a_rdy",    a_rdy, e_ardy);
        check_val("p_rdy",    p_rdy, e_prdy);
        check_val("send_val", send_val, m_pend);
        check_val("xr", xr, m_xr);
        check_val("xc", xc, m_xc);
        check_val("yr", yr, m_yr);
        check_val("yc", yc, m_yc);
        check_val("ovf", ovf, m_ovf);
        push   = !rs && av && e_ardy;
        jn     = !rs && pv && e_prdy;
        joined = jn;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            if (jn) begin
                a   = m_aq.pop_front();
                sat = 1'b0;
                m_xr = bfly(a.re, p_r, 1'b0, sat);
                m_xc = bfly(a.im, p_c, 1'b0, sat);
                m_yr = bfly(a.re, p_r, 1'b1, sat);
                m_yc = bfly(a.im, p_c, 1'b1, sat);
                m_pend = 1'b1;
                if (sat) m_ovf = 1'b1;
            end else if (m_pend && sr) begin
                m_pend = 1'b0;
            end
            if (push) m_aq.push_back('{re: a_r, im: a_c});
        end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    bit          j;
    int          idx;
    logic [31:0] pv_r [3];

    initial begin
        reset = 1'b1; a_val = 0; p_val = 0; send_rdy = 0;
        ar = '0; ac = '0; pr = '0; pc = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state: checked by the first idle cycle after deassertion.
        step(0, 0, 0, 0, 0, 0, 0, 1, j);

        // Basic join.
        step(0, 1, 32'h0001_0000, 32'h0, 0, 0, 0, 1, j);
        step(0, 0, 0, 0, 1, 32'h0000_8000, 32'h0000_4000, 1, j);
        #2;
        check_val("basic_send_val", send_val, 1'b1);
        check_val("basic_xr", xr, 32'h0001_8000);
        check_val("basic_xc", xc, 32'h0000_4000);
        check_val("basic_yr", yr, 32'h0000_8000);
        check_val("basic_yc", yc, 32'hFFFF_C000);
        step(0, 0, 0, 0, 0, 0, 0, 1, j);

        // Same-cycle A and P on an empty buffer.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        step(0, 1, 32'd5, 32'd7, 1, 32'd3, 32'd1, 1, j);
        step(0, 0, 0, 0, 1, 32'd3, 32'd1, 1, j);
        #2;
        check_val("same_send_val", send_val, 1'b1);
        check_val("same_xr", xr, 32'd8);
        check_val("same_yc", yc, 32'd6);
        step(0, 0, 0, 0, 0, 0, 0, 1, j);

        // Full buffer.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        for (int i = 0; i < 4; i++) step(0, 1, $urandom, $urandom, 0, 0, 0, 1, j);
        #2;
        check_val("full_count", a_count, 3'd4);
        check_val("full_a_rdy", a_rdy, 1'b0);
        step(0, 1, 32'h55, 32'h66, 0, 0, 0, 1, j);
        step(0, 1, 32'h55, 32'h66, 1, 32'h11, 32'h22, 1, j);
        #2;
        check_val("full_a_rdy_after_pop", a_rdy, 1'b1);
        check_val("full_count_after_pop", a_count, 3'd3);
        step(0, 1, 32'h55, 32'h66, 0, 0, 0, 1, j);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, $urandom, $urandom, 1, j);

        // Back-pressure with three products queued behind a stalled output.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        for (int i = 0; i < 3; i++) begin
            pv_r[i] = $urandom;
            step(0, 1, $urandom, $urandom, 0, 0, 0, 1, j);
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, idx < 3, pv_r[idx % 3], 32'h1, 0, j);
            if (j) idx++;
        end
        check_val("bp_one_join_while_stalled", idx, 1);
        for (int i = 0; i < 8 && (idx < 3 || m_pend); i++) begin
            step(0, 0, 0, 0, idx < 3, pv_r[idx % 3], 32'h1, 1, j);
            if (j) idx++;
        end
        check_val("bp_all_joined", idx, 3);

        // Reset mid-stream with buffered A and a pending result.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        for (int i = 0; i < 3; i++) step(0, 1, $urandom, $urandom, 0, 0, 0, 1, j);
        step(0, 0, 0, 0, 1, 32'h1234, 32'h5678, 0, j);
        step(1, 1, 32'h9, 32'h9, 1, 32'h9, 32'h9, 0, j);
        #2;
        check_val("rst_count", a_count, 3'd0);
        check_val("rst_send_val", send_val, 1'b0);
        check_val("rst_xr", xr, 32'h0);
        step(0, 0, 0, 0, 1, 32'h7, 32'h7, 1, j);
        step(0, 1, 32'h2, 32'h2, 1, 32'h7, 32'h7, 1, j);
        step(0, 0, 0, 0, 1, 32'h7, 32'h7, 1, j);
        step(0, 0, 0, 0, 0, 0, 0, 1, j);

        // Overflow on the real sum.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        step(0, 1, 32'h7FFF_0000, 32'h0, 0, 0, 0, 1, j);
        step(0, 0, 0, 0, 1, 32'h0002_0000, 32'h0, 1, j);
        #2;
`ifdef FIXED_POINT_BUTTERFLY_SAT_EN
        check_val("ovf_xr", xr, 32'h7FFF_FFFF);
`else
        check_val("ovf_xr", xr, 32'h8001_0000);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 1, j);
        step(0, 0, 0, 0, 0, 0, 0, 1, j);
        #2;
`ifdef FIXED_POINT_BUTTERFLY_SAT_EN
        check_val("ovf_sticky", ovf, 1'b1);
`else
        check_val("ovf_sticky", ovf, 1'b0);
`endif

        // Randomized traffic with occasional resets.
        step(1, 0, 0, 0, 0, 0, 0, 1, j);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(2) != 0, rnd_word(), rnd_word(),
                 $urandom_range(2) != 0, rnd_word(), rnd_word(),
                 $urandom_range(3) != 0, j);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
